// File: rtl/reg_bus_master.sv
// Byte-stream command bridge: parses 'W' addr data / 'R' addr commands and
// drives single accesses on the register bus, returning 'K' or read data.
module reg_bus_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_wr,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h4B;

  localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int WT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, WRITE, READ_WAIT, READ_CAP, TX
  } state_t;

  state_t                state_q, state_d;
  logic                  is_rd_q, is_rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  err_q, err_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [WT_W-1:0]       wait_q, wait_d;
  logic                  timeout_hit;

  // Counter holds the number of silent cycles seen so far; the next silent
  // cycle that would make it reach TIMEOUT_CYCLES aborts the command.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    is_rd_d    = is_rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    err_d      = 1'b0;
    to_cnt_d   = to_cnt_q;
    wait_d     = wait_q;
    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_WR || i_rx_data == CMD_RD) begin
            state_d  = GET_ADDR;
            is_rd_d  = (i_rx_data == CMD_RD);
            to_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GET_ADDR: begin
        if (i_rx_valid) begin
          addr_d   = i_rx_data[ADDR_WIDTH-1:0];
          to_cnt_d = '0;
          wait_d   = '0;
          if (is_rd_q) state_d = (READ_LATENCY == 0) ? READ_CAP : READ_WAIT;
          else         state_d = GET_DATA;
        end else if (timeout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      GET_DATA: begin
        if (i_rx_valid) begin
          wdata_d  = DATA_WIDTH'(i_rx_data);
          wr_d     = 1'b1;
          to_cnt_d = '0;
          state_d  = WRITE;
        end else if (timeout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      WRITE: begin
        tx_data_d  = ACK;
        tx_valid_d = 1'b1;
        state_d    = TX;
      end
      READ_WAIT: begin
        if (wait_q == WT_LAST) state_d = READ_CAP;
        else                   wait_d  = wait_q + 1'b1;
      end
      READ_CAP: begin
        tx_data_d  = 8'(i_rdata);
        tx_valid_d = 1'b1;
        state_d    = TX;
      end
      TX: begin
        if (i_tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // No backpressure on rx: bytes that land mid-transaction are discarded.
    if (i_rx_valid && (state_q == WRITE || state_q == READ_WAIT ||
                       state_q == READ_CAP || state_q == TX)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      is_rd_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      is_rd_q    <= is_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
      wait_q     <= wait_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_addr     = addr_q;
  assign o_wdata    = wdata_q;
  assign o_wr       = wr_q;
  assign o_err      = err_q;
  assign o_busy     = (state_q != IDLE);

endmodule
